// File: rtl/dpr_pkg.sv
// Shared constants and types for the dual-port byte-enable RAM.
package dpr_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  typedef enum logic {
    CLR_ST = 1'b0,
    RUN_ST = 1'b1
  } clr_state_t;

endpackage

// File: rtl/dpr_clear_fsm.sv
// Post-reset fill engine: walks every word address once, then hands the array to the ports.
module dpr_clear_fsm
  import dpr_pkg::*;
#(
  parameter int AW    = 14,
  parameter int CLEAR = 1
) (
  input  logic          clock,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_t    state;
  logic [AW-1:0] ptr;

  // The last address is written in the same cycle the FSM moves to RUN, so the fill takes 2**AW cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= (CLEAR != 0) ? CLR_ST : RUN_ST;
      ptr   <= '0;
      busy  <= (CLEAR != 0);
    end else begin
      case (state)
        CLR_ST: begin
          if (ptr == {AW{1'b1}}) begin
            state <= RUN_ST;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = ptr;

endmodule

// File: rtl/dpr_be.sv
// True dual-port RAM with byte enables, selectable read-during-write, optional output register,
// cross-port collision flag and a post-reset clear engine.
module dpr_be
  import dpr_pkg::*;
#(
  parameter int            DW        = 8,
  parameter int            AW        = 14,
  parameter int            RDW_MODE  = 0,
  parameter int            OREG      = 0,
  parameter int            CLEAR     = 1,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              busy,
  output logic              coll,
  input  logic              ce1,
  input  logic              we1,
  input  logic [DW/8-1:0]   be1,
  input  logic [AW-1:0]     a1,
  input  logic [DW-1:0]     di1,
  output logic [DW-1:0]     do1,
  output logic              vld1,
  input  logic              ce2,
  input  logic              we2,
  input  logic [DW/8-1:0]   be2,
  input  logic [AW-1:0]     a2,
  input  logic [DW-1:0]     di2,
  output logic [DW-1:0]     do2,
  output logic              vld2
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  generate
    if ((DW % 8) != 0 || DW < 8) begin : g_bad_dw
      $error("dpr_be: DW must be a non-zero multiple of 8");
    end
    if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST && RDW_MODE != RDW_NO_CHANGE) begin : g_bad_rdw
      $error("dpr_be: RDW_MODE must be 0, 1 or 2");
    end
  endgenerate

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] base,
                                          input logic [DW-1:0] data,
                                          input logic [NB-1:0] lanes);
    logic [DW-1:0] r;
    r = base;
    for (int i = 0; i < NB; i++) begin
      if (lanes[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  dpr_clear_fsm #(
    .AW    (AW),
    .CLEAR (CLEAR)
  ) u_clear (
    .clock    (clock),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [NB-1:0][7:0] mem [DEPTH];

  logic          run;
  logic          rd1, wr1, rd2, wr2;
  logic          same_addr;
  logic          p1w_en;
  logic [AW-1:0] p1w_addr;
  logic [NB-1:0] p1w_be;
  logic [DW-1:0] p1w_data;
  logic [DW-1:0] old1, old2;
  logic [DW-1:0] final1, final2;

  assign run       = ~busy;
  assign rd1       = run & ce1 & ~we1;
  assign wr1       = run & ce1 & we1;
  assign rd2       = run & ce2 & ~we2;
  assign wr2       = run & ce2 & we2;
  assign same_addr = (a1 == a2);

  // The clear engine borrows port 1's write path so the array keeps exactly two write ports.
  assign p1w_en   = clr_we | wr1;
  assign p1w_addr = clr_we ? clr_addr : a1;
  assign p1w_be   = clr_we ? {NB{1'b1}} : be1;
  assign p1w_data = clr_we ? CLEAR_VAL : di1;

  assign old1 = mem[a1];
  assign old2 = mem[a2];

  // Word as it will stand after this cycle's writes, port 1 taking lanes both ports enable.
  assign final1 = merge(merge(old1, di2, {NB{wr2 & same_addr}} & be2), di1, be1);
  assign final2 = merge(merge(old2, di2, be2), di1, {NB{wr1 & same_addr}} & be1);

  // Port 1 is written last so its lanes override port 2 on a same-address write/write.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (wr2 && be2[i]) mem[a2][i] <= di2[8*i +: 8];
      if (p1w_en && p1w_be[i]) mem[p1w_addr][i] <= p1w_data[8*i +: 8];
    end
  end

  logic [DW-1:0] s1_d1, s1_d2;
  logic          s1_v1, s1_v2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_d1 <= '0;
      s1_v1 <= 1'b0;
    end else if (rd1) begin
      s1_d1 <= old1;
      s1_v1 <= 1'b1;
    end else if (wr1 && RDW_MODE == RDW_WRITE_FIRST) begin
      s1_d1 <= final1;
      s1_v1 <= 1'b1;
    end else begin
      s1_v1 <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_d2 <= '0;
      s1_v2 <= 1'b0;
    end else if (rd2) begin
      s1_d2 <= old2;
      s1_v2 <= 1'b1;
    end else if (wr2 && RDW_MODE == RDW_WRITE_FIRST) begin
      s1_d2 <= final2;
      s1_v2 <= 1'b1;
    end else begin
      s1_v2 <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) coll <= 1'b0;
    else       coll <= run & ce1 & ce2 & same_addr & (we1 | we2);
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] s2_d1, s2_d2;
      logic          s2_v1, s2_v2;

      // Data only advances with a valid beat so the output keeps holding the last read.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s2_d1 <= '0;
          s2_d2 <= '0;
          s2_v1 <= 1'b0;
          s2_v2 <= 1'b0;
        end else begin
          s2_v1 <= s1_v1;
          s2_v2 <= s1_v2;
          if (s1_v1) s2_d1 <= s1_d1;
          if (s1_v2) s2_d2 <= s1_d2;
        end
      end

      assign do1  = s2_d1;
      assign do2  = s2_d2;
      assign vld1 = s2_v1;
      assign vld2 = s2_v2;
    end else begin : g_no_oreg
      assign do1  = s1_d1;
      assign do2  = s1_d2;
      assign vld1 = s1_v1;
      assign vld2 = s1_v2;
    end
  endgenerate

endmodule

// File: tb/tb_dpr_be.sv
// Directed bench for dpr_be: four parameter variants share one stimulus bus.
module tb_dpr_be;

  logic        clock;
  logic        reset;
  logic        ce1, we1, ce2, we2;
  logic [1:0]  be1, be2;
  logic [3:0]  a1, a2;
  logic [15:0] di1, di2;

  logic [15:0] do1_w [4];
  logic [15:0] do2_w [4];
  logic [3:0]  vld1_w, vld2_w, coll_w, busy_w;

  int checks;
  int failures;

  // u0: read-first, clear to A5A5; u1: write-first; u2: no-change; u3: output register + clear.
  dpr_be #(.DW(16), .AW(4), .RDW_MODE(0), .OREG(0), .CLEAR(1), .CLEAR_VAL(16'hA5A5)) u0 (
    .clock(clock), .reset(reset), .busy(busy_w[0]), .coll(coll_w[0]),
    .ce1(ce1), .we1(we1), .be1(be1), .a1(a1), .di1(di1), .do1(do1_w[0]), .vld1(vld1_w[0]),
    .ce2(ce2), .we2(we2), .be2(be2), .a2(a2), .di2(di2), .do2(do2_w[0]), .vld2(vld2_w[0]));

  dpr_be #(.DW(16), .AW(4), .RDW_MODE(1), .OREG(0), .CLEAR(0), .CLEAR_VAL(16'h0000)) u1 (
    .clock(clock), .reset(reset), .busy(busy_w[1]), .coll(coll_w[1]),
    .ce1(ce1), .we1(we1), .be1(be1), .a1(a1), .di1(di1), .do1(do1_w[1]), .vld1(vld1_w[1]),
    .ce2(ce2), .we2(we2), .be2(be2), .a2(a2), .di2(di2), .do2(do2_w[1]), .vld2(vld2_w[1]));

  dpr_be #(.DW(16), .AW(4), .RDW_MODE(2), .OREG(0), .CLEAR(0), .CLEAR_VAL(16'h0000)) u2 (
    .clock(clock), .reset(reset), .busy(busy_w[2]), .coll(coll_w[2]),
    .ce1(ce1), .we1(we1), .be1(be1), .a1(a1), .di1(di1), .do1(do1_w[2]), .vld1(vld1_w[2]),
    .ce2(ce2), .we2(we2), .be2(be2), .a2(a2), .di2(di2), .do2(do2_w[2]), .vld2(vld2_w[2]));

  dpr_be #(.DW(16), .AW(4), .RDW_MODE(0), .OREG(1), .CLEAR(1), .CLEAR_VAL(16'hA5A5)) u3 (
    .clock(clock), .reset(reset), .busy(busy_w[3]), .coll(coll_w[3]),
    .ce1(ce1), .we1(we1), .be1(be1), .a1(a1), .di1(di1), .do1(do1_w[3]), .vld1(vld1_w[3]),
    .ce2(ce2), .we2(we2), .be2(be2), .a2(a2), .di2(di2), .do2(do2_w[3]), .vld2(vld2_w[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    ce1 = 1'b0; we1 = 1'b0; be1 = 2'b00; a1 = 4'd0; di1 = 16'h0000;
    ce2 = 1'b0; we2 = 1'b0; be2 = 2'b00; a2 = 4'd0; di2 = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    idle();
    tick();
    checks++;
    if (busy_w !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL reset_busy got=%b exp=%b", busy_w, 4'b1001);
    end
    checks++;
    if ({vld1_w, vld2_w, coll_w} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%h exp=000", {vld1_w, vld2_w, coll_w});
    end
    checks++;
    if (do1_w[0] !== 16'h0000 || do2_w[3] !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_do got=%h/%h exp=0000/0000", do1_w[0], do2_w[3]);
    end
    reset = 1'b0;
    n = 0;
    while (busy_w[0] && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("[TB] FAIL clear_cycles got=%0d exp=16", n);
    end
    checks++;
    if (busy_w !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL busy_after_clear got=%b exp=0000", busy_w);
    end
  endtask

  task automatic test_clear_read();
    for (int i = 0; i < 16; i++) begin
      idle();
      ce1 = 1'b1;
      a1  = 4'(i);
      tick();
      checks++;
      if ({vld1_w[0], do1_w[0]} !== {1'b1, 16'hA5A5}) begin
        failures++;
        $display("[TB] FAIL clear_read[%0d] got=%b/%h exp=1/a5a5", i, vld1_w[0], do1_w[0]);
      end
    end
    idle();
  endtask

  task automatic test_byte_enable();
    idle();
    ce1 = 1'b1; we1 = 1'b1; a1 = 4'd3; di1 = 16'h1234; be1 = 2'b01;
    tick();
    di1 = 16'hFFFF; be1 = 2'b00;
    tick();
    idle();
    ce2 = 1'b1; a2 = 4'd3;
    tick();
    checks++;
    if ({vld2_w[0], do2_w[0]} !== {1'b1, 16'hA534}) begin
      failures++;
      $display("[TB] FAIL byte_lane_read got=%b/%h exp=1/a534", vld2_w[0], do2_w[0]);
    end
    idle();
    tick();
    checks++;
    if ({vld2_w[0], do2_w[0]} !== {1'b0, 16'hA534}) begin
      failures++;
      $display("[TB] FAIL do_hold got=%b/%h exp=0/a534", vld2_w[0], do2_w[0]);
    end
  endtask

  task automatic test_write_write();
    idle();
    ce1 = 1'b1; we1 = 1'b1; a1 = 4'd5; di1 = 16'h0011; be1 = 2'b11;
    ce2 = 1'b1; we2 = 1'b1; a2 = 4'd5; di2 = 16'h0022; be2 = 2'b11;
    tick();
    checks++;
    if (coll_w[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL coll_ww got=%b exp=1", coll_w[0]);
    end
    a1 = 4'd6; di1 = 16'hAAAA; be1 = 2'b01;
    a2 = 4'd6; di2 = 16'hBBBB; be2 = 2'b11;
    tick();
    idle();
    tick();
    checks++;
    if (coll_w[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL coll_pulse_width got=%b exp=0", coll_w[0]);
    end
    ce1 = 1'b1; a1 = 4'd5;
    ce2 = 1'b1; a2 = 4'd6;
    tick();
    checks++;
    if (do1_w[0] !== 16'h0011) begin
      failures++;
      $display("[TB] FAIL ww_full_priority got=%h exp=0011", do1_w[0]);
    end
    checks++;
    if (do2_w[0] !== 16'hBBAA) begin
      failures++;
      $display("[TB] FAIL ww_lane_merge got=%h exp=bbaa", do2_w[0]);
    end
    idle();
  endtask

  task automatic test_read_write();
    idle();
    ce1 = 1'b1; we1 = 1'b1; a1 = 4'd7; di1 = 16'h0033; be1 = 2'b11;
    tick();
    di1 = 16'h0044;
    ce2 = 1'b1; we2 = 1'b0; a2 = 4'd7;
    tick();
    checks++;
    if ({vld2_w[0], do2_w[0]} !== {1'b1, 16'h0033}) begin
      failures++;
      $display("[TB] FAIL rw_old_data got=%b/%h exp=1/0033", vld2_w[0], do2_w[0]);
    end
    checks++;
    if (coll_w[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL coll_rw got=%b exp=1", coll_w[0]);
    end
    idle();
    ce1 = 1'b1; a1 = 4'd7;
    ce2 = 1'b1; a2 = 4'd7;
    tick();
    checks++;
    if (do2_w[0] !== 16'h0044 || do1_w[0] !== 16'h0044) begin
      failures++;
      $display("[TB] FAIL rw_new_data got=%h/%h exp=0044/0044", do1_w[0], do2_w[0]);
    end
    checks++;
    if (coll_w[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL coll_rr got=%b exp=0", coll_w[0]);
    end
    idle();
    tick();
  endtask

  task automatic test_rdw_modes();
    idle();
    ce1 = 1'b1; we1 = 1'b1; a1 = 4'd2; di1 = 16'h005A; be1 = 2'b11;
    tick();
    checks++;
    if ({vld1_w[1], do1_w[1]} !== {1'b1, 16'h005A}) begin
      failures++;
      $display("[TB] FAIL rdw_write_first got=%b/%h exp=1/005a", vld1_w[1], do1_w[1]);
    end
    checks++;
    if ({vld1_w[0], do1_w[0]} !== {1'b0, 16'h0044}) begin
      failures++;
      $display("[TB] FAIL rdw_read_first got=%b/%h exp=0/0044", vld1_w[0], do1_w[0]);
    end
    checks++;
    if ({vld1_w[2], do1_w[2]} !== {1'b0, 16'h0044}) begin
      failures++;
      $display("[TB] FAIL rdw_no_change got=%b/%h exp=0/0044", vld1_w[2], do1_w[2]);
    end
    idle();
    ce2 = 1'b1; a2 = 4'd2;
    tick();
    checks++;
    if (do2_w[2] !== 16'h005A) begin
      failures++;
      $display("[TB] FAIL rdw_no_change_stored got=%h exp=005a", do2_w[2]);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back_oreg();
    idle();
    ce1 = 1'b1; a1 = 4'd5;
    tick();
    checks++;
    if (vld1_w[3] !== 1'b0 || {vld1_w[0], do1_w[0]} !== {1'b1, 16'h0011}) begin
      failures++;
      $display("[TB] FAIL oreg_first_cycle got=%b,%b/%h exp=0,1/0011", vld1_w[3], vld1_w[0], do1_w[0]);
    end
    a1 = 4'd6;
    tick();
    checks++;
    if ({vld1_w[3], do1_w[3]} !== {1'b1, 16'h0011}) begin
      failures++;
      $display("[TB] FAIL oreg_latency2 got=%b/%h exp=1/0011", vld1_w[3], do1_w[3]);
    end
    idle();
    tick();
    checks++;
    if ({vld1_w[3], do1_w[3]} !== {1'b1, 16'hBBAA}) begin
      failures++;
      $display("[TB] FAIL oreg_back_to_back got=%b/%h exp=1/bbaa", vld1_w[3], do1_w[3]);
    end
    tick();
    checks++;
    if ({vld1_w[3], do1_w[3]} !== {1'b0, 16'hBBAA}) begin
      failures++;
      $display("[TB] FAIL oreg_hold got=%b/%h exp=0/bbaa", vld1_w[3], do1_w[3]);
    end
  endtask

  task automatic test_clear_restart();
    int n;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (9) tick();
    checks++;
    if (busy_w[3] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_mid_clear got=%b exp=1", busy_w[3]);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (busy_w[3] !== 1'b1 || do1_w[3] !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL mid_clear_reset got=%b/%h exp=1/0000", busy_w[3], do1_w[3]);
    end
    reset = 1'b0;
    n = 0;
    while (busy_w[3] && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("[TB] FAIL restart_cycles got=%0d exp=16", n);
    end
    ce1 = 1'b1; a1 = 4'd5;
    tick();
    idle();
    tick();
    checks++;
    if ({vld1_w[3], do1_w[3]} !== {1'b1, 16'hA5A5}) begin
      failures++;
      $display("[TB] FAIL restart_refill got=%b/%h exp=1/a5a5", vld1_w[3], do1_w[3]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    test_reset();
    test_clear_read();
    test_byte_enable();
    test_write_write();
    test_read_write();
    test_rdw_modes();
    test_back_to_back_oreg();
    test_clear_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
